// File: rtl/radix4_mult_seq.sv
// Sequential radix-4 unsigned multiplier driving one external x0..x4 scaler; p = a*b.
// Optional early termination: define RADIX4_MULT_EARLY_TERM_EN.
module radix4_mult_seq #(
  parameter int B_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       a,
  input  logic [B_W-1:0]   b,
  output logic             busy,
  output logic             done,
  output logic [8+B_W-1:0] p,
  output logic [7:0]       sc_i,
  output logic [4:0]       sc_m,
  input  logic [9:0]       sc_o
);

  localparam int ND    = B_W / 2;
  localparam int P_W   = 8 + B_W;
  localparam int CNT_W = (ND > 1) ? $clog2(ND) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [7:0]       a_r;
  logic [B_W-1:0]   b_r;
  logic [P_W-1:0]   acc;
  logic [P_W-1:0]   p_r;
  logic [CNT_W-1:0] cnt;

  logic [P_W-1:0]   term;
  logic [P_W-1:0]   acc_next;
  logic [CNT_W:0]   shamt;
  logic             last;

  // Digit 0 selects the scaler's zero leg; its output is never accumulated.
  function automatic logic [4:0] digit_sel(input logic [1:0] d);
    return 5'b00001 << d;
  endfunction

  always_comb begin
    sc_i = 8'd0;
    sc_m = 5'b00000;
    if (state == S_RUN) begin
      sc_i = a_r;
      sc_m = digit_sel(b_r[1:0]);
    end
  end

  always_comb begin
    shamt    = {cnt, 1'b0};
    term     = '0;
    if (b_r[1:0] != 2'd0)
      term = P_W'(sc_o) << shamt;
    acc_next = acc + term;
    last     = (cnt == CNT_W'(ND - 1));
`ifdef RADIX4_MULT_EARLY_TERM_EN
    if ((b_r >> 2) == '0)
      last = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      p_r   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            acc   <= '0;
            cnt   <= '0;
            state <= S_RUN;
`ifdef RADIX4_MULT_EARLY_TERM_EN
            if (b == '0) begin
              p_r   <= '0;
              state <= S_DONE;
            end
`endif
          end
        end
        // One radix-4 digit per cycle; p tracks the running sum and is final on exit.
        S_RUN: begin
          acc <= acc_next;
          p_r <= acc_next;
          b_r <= b_r >> 2;
          cnt <= cnt + CNT_W'(1);
          if (last)
            state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign p    = p_r;

endmodule

// File: tb/tb_radix4_mult_seq.sv
// Randomized self-checking bench for radix4_mult_seq (B_W=8) with a behavioural scaler
// and a reference model of product, digit-select sequence and latency.
module tb_radix4_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;
  logic [7:0]  sc_i;
  logic [4:0]  sc_m;
  logic [9:0]  sc_o;

  int checks = 0;
  int errors = 0;

  radix4_mult_seq #(.B_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .p(p),
    .sc_i(sc_i), .sc_m(sc_m), .sc_o(sc_o)
  );

  always #5 clk = ~clk;

  // External scaler; the zero leg returns junk so any use of it shows up in p.
  always_comb begin
    case (sc_m)
      5'b00001: sc_o = 10'h155;
      5'b00010: sc_o = 10'(sc_i);
      5'b00100: sc_o = 10'(sc_i) * 10'd2;
      5'b01000: sc_o = 10'(sc_i) * 10'd3;
      5'b10000: sc_o = 10'(sc_i) * 10'd4;
      default:  sc_o = 10'h2AA;
    endcase
  end

  function automatic int run_len(input logic [7:0] bv);
    int hi;
`ifdef RADIX4_MULT_EARLY_TERM_EN
    if (bv == 8'd0) return 0;
    hi = 0;
    for (int i = 0; i < 4; i++)
      if (((bv >> (2 * i)) & 8'd3) != 0) hi = i;
    return hi + 1;
`else
    hi = 4;
    return hi + 0 * int'(bv);
`endif
  endfunction

  task automatic do_mult(input logic [7:0] ta, input logic [7:0] tb);
    logic [15:0] exp_p;
    logic [4:0]  exp_m;
    int          len;
    bit          seen;
    exp_p = 16'(ta) * 16'(tb);
    len   = run_len(tb);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_start: busy=%0b expected 0", busy);
    end
    start = 1'b1; a = ta; b = tb;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    seen = 1'b0;
    for (int cyc = 1; cyc <= 12 && !seen; cyc++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (cyc != len + 1) begin
          errors++;
          $display("FAIL done_latency a=%0d b=%0d: done in cycle E+%0d expected E+%0d", ta, tb, cyc, len + 1);
        end
        checks++;
        if (p !== exp_p) begin
          errors++;
          $display("FAIL product a=%0d b=%0d: p=%0d expected %0d", ta, tb, p, exp_p);
        end
        checks++;
        if (busy !== 1'b1 || sc_m !== 5'b00000) begin
          errors++;
          $display("FAIL done_outputs: busy=%0b sc_m=%b expected busy=1 sc_m=00000", busy, sc_m);
        end
      end else begin
        if (cyc <= len) begin
          exp_m = 5'b00001 << ((tb >> (2 * (cyc - 1))) & 8'd3);
          checks++;
          if (sc_m !== exp_m || sc_i !== ta || busy !== 1'b1) begin
            errors++;
            $display("FAIL run_drive a=%0d b=%0d k=%0d: sc_m=%b sc_i=%0d busy=%0b expected sc_m=%b sc_i=%0d busy=1",
                     ta, tb, cyc - 1, sc_m, sc_i, busy, exp_m, ta);
          end
        end
        @(negedge clk);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout a=%0d b=%0d: no done within 12 cycles, expected at E+%0d", ta, tb, len + 1);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || p !== exp_p || sc_m !== 5'b00000 || sc_i !== 8'd0) begin
      errors++;
      $display("FAIL after_done a=%0d b=%0d: done=%0b busy=%0b p=%0d sc_m=%b sc_i=%0d expected 0,0,%0d,00000,0",
               ta, tb, done, busy, p, sc_m, sc_i, exp_p);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'hFF; b = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== 16'd0 || sc_i !== 8'd0 || sc_m !== 5'b00000) begin
      errors++;
      $display("FAIL reset_state: busy=%0b done=%0b p=%0d sc_i=%0d sc_m=%b expected all zero",
               busy, done, p, sc_i, sc_m);
    end
  endtask

  task automatic test_directed();
    do_mult(8'd200, 8'd255);
    repeat (3) @(negedge clk);
    checks++;
    if (p !== 16'd51000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL p_hold: p=%0d busy=%0b expected p=51000 busy=0", p, busy);
    end
    do_mult(8'h5A, 8'h1B);
    do_mult(8'd255, 8'd0);
    do_mult(8'd17, 8'd3);
    do_mult(8'd255, 8'd255);
    do_mult(8'd0, 8'd255);
  endtask

  task automatic test_ignore_start();
    int ndone;
    start = 1'b1; a = 8'd200; b = 8'd255;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 8'd1; b = 8'd1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (p !== 16'd51000) begin
          errors++;
          $display("FAIL ignore_start_product: p=%0d expected 51000", p);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL ignore_start_done_count: saw %0d done pulses expected 1", ndone);
    end
  endtask

  task automatic test_reset_abort();
    int ndone;
    start = 1'b1; a = 8'd200; b = 8'd255;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== 16'd0 || sc_m !== 5'b00000) begin
      errors++;
      $display("FAIL reset_abort: busy=%0b done=%0b p=%0d sc_m=%b expected 0,0,0,00000", busy, done, p, sc_m);
    end
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL reset_abort_no_done: saw %0d done pulses expected 0", ndone);
    end
    do_mult(8'd3, 8'd3);
  endtask

  task automatic test_hold_start();
    int t_done[$];
    int len;
    len = run_len(8'd9);
    start = 1'b1; a = 8'd7; b = 8'd9;
    for (int i = 0; i < 30 && t_done.size() < 2; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        t_done.push_back(i);
        checks++;
        if (p !== 16'd63) begin
          errors++;
          $display("FAIL hold_start_product: p=%0d expected 63", p);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (t_done.size() != 2) begin
      errors++;
      $display("FAIL hold_start_retrigger: saw %0d done pulses expected 2", t_done.size());
    end else if (t_done[1] - t_done[0] != len + 2) begin
      errors++;
      $display("FAIL hold_start_spacing: done spacing %0d cycles expected %0d", t_done[1] - t_done[0], len + 2);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      case (i % 8)
        0:       do_mult(8'($urandom), 8'd0);
        1:       do_mult(8'($urandom), 8'($urandom_range(1, 3)));
        2:       do_mult(8'($urandom), 8'($urandom_range(0, 15)));
        default: do_mult(8'($urandom), 8'($urandom));
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_hold_start();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
